// File: rtl/iopad_bank_cfg.sv
// N-channel I/O pad bank. Each channel has a bypass or registered path in each
// direction, set by a 4-bit slice of a serial config chain, plus one scan chain.
module iopad_bank_cfg #(
  parameter int NUM_CH    = 4,
  parameter int IN_STAGES = 2,
  localparam int CFG_BITS = 4
) (
  input  logic              iopad_clk,
  input  logic              global_reset,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              scan_enable,
  input  logic              iopad_sc_in,
  output logic              iopad_sc_out,
  input  logic [NUM_CH-1:0] iopad_f2a_i,
  input  logic [NUM_CH-1:0] iopad_oe_i,
  output logic [NUM_CH-1:0] iopad_a2f_o,
  input  logic [NUM_CH-1:0] gfpga_pad_A2F,
  output logic [NUM_CH-1:0] gfpga_pad_F2A,
  output logic [NUM_CH-1:0] gfpga_pad_OE
);

  localparam int CFG_W  = CFG_BITS * NUM_CH;
  localparam int CH_LEN = 2 + IN_STAGES;
  localparam int CHAIN  = CH_LEN * NUM_CH;

  // Slice layout within one channel's cfg nibble
  localparam int B_OUT_REG = 0;
  localparam int B_IN_REG  = 1;
  localparam int B_OE_REG  = 2;
  localparam int B_INV     = 3;

  logic [CFG_W-1:0] cfg;

  // All data FFs in scan order: per channel out_ff, oe_ff, in_ff[0..IN_STAGES-1]
  logic [CHAIN-1:0] chain;
  logic [CHAIN-1:0] chain_nxt;

  always_ff @(posedge iopad_clk or posedge global_reset) begin
    if (global_reset) begin
      cfg <= '0;
    end else if (config_enable) begin
      cfg <= {cfg[CFG_W-2:0], ccff_head};
    end
  end

  always_comb begin
    chain_nxt = chain;
    if (config_enable) begin
      chain_nxt = chain;
    end else if (scan_enable) begin
      chain_nxt = {chain[CHAIN-2:0], iopad_sc_in};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        chain_nxt[k*CH_LEN]     = iopad_f2a_i[k];
        chain_nxt[k*CH_LEN + 1] = iopad_oe_i[k];
        chain_nxt[k*CH_LEN + 2] = gfpga_pad_A2F[k];
        for (int i = 1; i < IN_STAGES; i++) begin
          chain_nxt[k*CH_LEN + 2 + i] = chain[k*CH_LEN + 1 + i];
        end
      end
    end
  end

  always_ff @(posedge iopad_clk or posedge global_reset) begin
    if (global_reset) begin
      chain <= '0;
    end else begin
      chain <= chain_nxt;
    end
  end

  assign ccff_tail    = cfg[CFG_W-1];
  assign iopad_sc_out = chain[CHAIN-1];

  // Output muxes track cfg live, so they change as config bits shift past
  always_comb begin
    gfpga_pad_F2A = '0;
    gfpga_pad_OE  = '0;
    iopad_a2f_o   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      gfpga_pad_F2A[k] = (cfg[k*CFG_BITS + B_OUT_REG] ? chain[k*CH_LEN] : iopad_f2a_i[k])
                         ^ cfg[k*CFG_BITS + B_INV];
      gfpga_pad_OE[k]  = (cfg[k*CFG_BITS + B_OE_REG] ? chain[k*CH_LEN + 1] : iopad_oe_i[k])
                         & ~config_enable & ~global_reset;
      iopad_a2f_o[k]   = cfg[k*CFG_BITS + B_IN_REG] ? chain[k*CH_LEN + 1 + IN_STAGES]
                                                    : gfpga_pad_A2F[k];
    end
  end

endmodule
